mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/aurora_mem_pkg.sv | 21 ++
 rtl/mem_arb_prio.sv | 43 ++++
 rtl/mem_arbiter.sv | 84 ++++++++
 3 files changed

// File: rtl/aurora_mem_pkg.sv
// Shared types for the instruction/load-store SRAM arbiter.
// This package holds the response-owner encoding and the default data width.
package aurora_mem_pkg;

  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LSU  = 2'd2
  } owner_e;

  // Only reads leave a response one cycle later.
  function automatic owner_e next_owner(input logic i_gnt, input logic d_gnt,
                                        input logic d_we);
    if (i_gnt) return OWN_IF;
    if (d_gnt && !d_we) return OWN_LSU;
    return OWN_NONE;
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Grant priority between ifetch and load/store.
// Load/store normally wins; an ifetch that has lost STARVE_MAX consecutive cycles wins next.
module mem_arb_prio
  import aurora_mem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic d_req,
  output logic i_win,
  output logic d_win
);

  localparam int CNT_W = ($clog2(STARVE_MAX + 1) > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             starved;

  assign starved = (starve_q == CNT_W'(STARVE_MAX));

  always_comb begin
    i_win = 1'b0;
    d_win = 1'b0;
    if (!rst) begin
      if (d_req && !(i_req && starved)) d_win = 1'b1;
      else if (i_req)                   i_win = 1'b1;
    end
  end

  // Count only cycles in which a pending ifetch lost; saturate at the limit.
  always_comb begin
    starve_d = '0;
    if (i_req && !i_win) starve_d = starved ? starve_q : starve_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (ifetch read-only, load/store) arbiter in front of a single-port SRAM
// with 1-cycle read latency; one access per cycle, responses routed by owner tag.
module mem_arbiter
  import aurora_mem_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [31:0]         i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [31:0]         d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  logic   i_win, d_win;
  owner_e owner_q, owner_d;

  mem_arb_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .clk   (clk),
    .rst   (rst),
    .i_req (i_req),
    .d_req (d_req),
    .i_win (i_win),
    .d_win (d_win)
  );

  assign i_gnt = i_win;
  assign d_gnt = d_win;

  // Byte address to word address; sub-word and out-of-range bits are dropped.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_win) begin
      mem_en    = 1'b1;
      mem_addr  = d_addr[ADDR_W+1:2];
      mem_wdata = d_wdata;
      if (d_we) mem_we = d_be;
    end else if (i_win) begin
      mem_en    = 1'b1;
      mem_addr  = i_addr[ADDR_W+1:2];
      mem_wdata = d_wdata;
    end
  end

  assign owner_d = next_owner(i_win, d_win, d_we);

  always_ff @(posedge clk) begin
    if (rst) owner_q <= OWN_NONE;
    else     owner_q <= owner_d;
  end

  // A reset landing in the response cycle drops that response.
  assign i_rvalid = !rst && (owner_q == OWN_IF);
  assign d_rvalid = !rst && (owner_q == OWN_LSU);
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                              d_addr[31:ADDR_W+2], d_addr[1:0]};

endmodule
